bilinear_scale_ctrl: RTL and testbench
======================================

// Module: bilinear_scale_ctrl
// PURPOSE
//  Frame sequencer for the bilinear datapath. Scans destination pixels in raster order and tracks the
//  source coordinate in Q.9 fixed point. Issues the four neighbour read addresses to source pixel RAM.
//  Emits coefficient1..4 and en_b aligned to the RAM read data, ready for the bilinear_cal inputs.
// PARAMETERS
//  DIM_W   11  width of image width/height fields (max 2047 px)
//  ADDR_W  21  source RAM address width
//  RD_LAT  1   source RAM read latency in cycles, 1..4
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: latch config, begin frame (ignored while busy)
//  src_w      in   DIM_W   source width in pixels, >=1
//  src_h      in   DIM_W   source height in pixels, >=1
//  dst_w      in   DIM_W   destination width, >=1
//  dst_h      in   DIM_W   destination height, >=1
//  step_x     in   16      Q7.9 horizontal source step per destination pixel (512 = 1.0)
//  step_y     in   16      Q7.9 vertical source step per destination row
//  hold       in   1       downstream not ready: freeze scan this cycle
//  busy       out  1       frame in progress
//  done       out  1       1-cycle pulse when the final en_b of the frame is issued
//  rd_en      out  1       read strobe for the four addresses
//  addr_bx    out  ADDR_W  (x0,y0)
//  addr_bx1   out  ADDR_W  (x1,y0)
//  addr_by    out  ADDR_W  (x0,y1)
//  addr_by1   out  ADDR_W  (x1,y1)
//  coefficient1..4  out 10 each: 512-fx, fx, 512-fy, fy (9 fractional bits)
//  en_b       out  1       valid for coefficients and RAM data (goes to bilinear_cal en_b)
//  eol        out  1       aligned with en_b on the last pixel of each destination row
// BEHAVIOUR
//  Reset: every output 0, FSM in IDLE, accumulators 0.
//  FSM IDLE -start-> LINE_SETUP -> RUN -(last dst column)-> LINE_SETUP | FLUSH (last row)
//   FLUSH -(RD_LAT cycles)-> IDLE. busy=1 in every state except IDLE.
//  LINE_SETUP (1 cycle): y0=sy[int], fy=sy[8:0]; registered row bases y0*src_w and y1*src_w; sx=0.
//  RUN: one destination pixel per cycle when hold=0. Computes x0=sx[int], fx=sx[8:0].
//   Drives rd_en=1 and the four addresses (each = row base + column), then sx+=step_x.
//   With hold=1: rd_en=0, scan state frozen, alignment delay line keeps shifting.
//  After the last column of a row: sy+=step_y and return to LINE_SETUP. After the last row: FLUSH.
//  Alignment: coefficients, en_b and eol are rd_en-cycle values delayed by exactly RD_LAT cycles.
//   Coefficients hold their last value while en_b=0.
//  Arithmetic: sx/sy are DIM_W+9 bits. Coefficients are exact 10-bit values.
//   fx=0 gives coefficient1=512, coefficient2=0. Accumulators saturate, never wrap.
//  start while busy is ignored; config is sampled only on start in IDLE.
//  rst_n low mid-frame: immediate IDLE, all outputs 0, no done pulse.
//  Leading/trailing edge: done coincides with the final en_b; busy drops the next cycle.
// CONFIGURATION
//  BILINEAR_CTRL_EDGE_CLAMP_EN defined: x1=min(x0+1,src_w-1) and y1=min(y0+1,src_h-1).
//   Also x0>=src_w-1 forces x0=x1=src_w-1 with fx=0; same for y.
//   Result: all addresses lie inside the src_w*src_h image.
//  Undefined: x1=x0+1, y1=y0+1 with no clamping. The RAM must carry one padding column and one
//   padding row. fx/fy are taken unmodified.
// STRUCTURE
//  bilinear_pkg: FRAC_BITS=9, COEF_ONE=10'd512, state enum {IDLE,LINE_SETUP,RUN,FLUSH}.
//  Sub-module bilinear_align_dly: RD_LAT-deep shift register for {coef1..4,en_b,eol}.
// TESTING
//  4x4->4x4, step=512: 16 en_b, addr_bx=0..15, coef1=512, coef2=0, coef3=512, coef4=0; done on 16th.
//  2x2->4x4, step=256, clamp on: pixel(1,0) coef1=256, coef2=256; pixel(3,0) addr_bx=addr_bx1=1.
//  Clamp off, same frame: pixel(3,0) addr_bx1=2, pixel(0,3) addr_by=4 (padding address).
//  hold high 3 cycles mid-row: exactly 3 en_b gaps, addr sequence resumes unchanged, total en_b=dst_w*dst_h.
//  RD_LAT=3: en_b rises 3 cycles after first rd_en; eol on each 4th en_b for dst_w=4.
//  rst_n low mid-row: outputs 0 next edge; start re-pulse restarts at addr 0; start while busy ignored.

Source files
------------

// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scaler control path.
package bilinear_pkg;

   localparam int unsigned FRAC_BITS = 9;
   localparam int unsigned COEF_W    = 10;
   localparam logic [COEF_W-1:0] COEF_ONE = 10'd512;

   typedef enum logic [1:0] {
      IDLE,
      LINE_SETUP,
      RUN,
      FLUSH
   } state_e;

   // Per-pixel payload travelling alongside the RAM read latency
   typedef struct packed {
      logic [COEF_W-1:0] c1;
      logic [COEF_W-1:0] c2;
      logic [COEF_W-1:0] c3;
      logic [COEF_W-1:0] c4;
      logic              en;
      logic              eol;
      logic              last;
   } align_t;

endpackage

// File: rtl/bilinear_align_dly.sv
// Delays the per-pixel payload by RD_LAT cycles so it meets the RAM read data.
// Coefficient fields only load on valid beats, so they hold while en is low.
module bilinear_align_dly
   import bilinear_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  align_t d_i,
   output align_t q_o
);

   align_t stage_q  [RD_LAT];
   align_t stage_in [RD_LAT];

   // Input of each stage: the payload for stage 0, the previous stage otherwise
   always_comb begin
      stage_in[0] = d_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         stage_in[i] = stage_q[i-1];
      end
   end

   // Shift strobes every cycle; coefficients advance only with a valid beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            stage_q[i].en   <= stage_in[i].en;
            stage_q[i].eol  <= stage_in[i].eol;
            stage_q[i].last <= stage_in[i].last;
            if (stage_in[i].en) begin
               stage_q[i].c1 <= stage_in[i].c1;
               stage_q[i].c2 <= stage_in[i].c2;
               stage_q[i].c3 <= stage_in[i].c3;
               stage_q[i].c4 <= stage_in[i].c4;
            end
         end
      end
   end

   assign q_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/bilinear_scale_ctrl.sv
// Frame sequencer for the bilinear datapath: raster scan of destination pixels,
// Q.9 source coordinate tracking, four neighbour addresses and aligned coefficients.
// Build option: BILINEAR_CTRL_EDGE_CLAMP_EN keeps all neighbours inside the source image.
module bilinear_scale_ctrl
   import bilinear_pkg::*;
#(
   parameter int unsigned DIM_W  = 11,
   parameter int unsigned ADDR_W = 21,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  src_w,
   input  logic [DIM_W-1:0]  src_h,
   input  logic [DIM_W-1:0]  dst_w,
   input  logic [DIM_W-1:0]  dst_h,
   input  logic [15:0]       step_x,
   input  logic [15:0]       step_y,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr_bx,
   output logic [ADDR_W-1:0] addr_bx1,
   output logic [ADDR_W-1:0] addr_by,
   output logic [ADDR_W-1:0] addr_by1,
   output logic [COEF_W-1:0] coefficient1,
   output logic [COEF_W-1:0] coefficient2,
   output logic [COEF_W-1:0] coefficient3,
   output logic [COEF_W-1:0] coefficient4,
   output logic              en_b,
   output logic              eol
);

   localparam int unsigned ACC_W = DIM_W + FRAC_BITS;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned X_W   = DIM_W + 1;
   localparam int unsigned CNT_W = 3;

   state_e              state_q;
   logic [DIM_W-1:0]    src_w_q, dst_w_q, dst_h_q;
   logic [15:0]         step_x_q, step_y_q;
   logic [ACC_W-1:0]    sx_q, sy_q, sx_d, sy_d;
   logic [SUM_W-1:0]    sx_sum, sy_sum;
   logic [DIM_W-1:0]    col_q, row_q;
   logic [ADDR_W-1:0]   base0_q, base1_q;
   logic [FRAC_BITS-1:0] fy_q;
   logic [CNT_W-1:0]    flush_q;
   logic                busy_q, rd_en_q;
   logic [ADDR_W-1:0]   addr0_q, addr1_q, addr2_q, addr3_q;
   align_t              pre_q, dly_q;

   logic [X_W-1:0]       x0, x1, y0, y1;
   logic [FRAC_BITS-1:0] fx, fy;
   logic                 last_col, last_row;

`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
   logic [DIM_W-1:0] src_h_q;
`else
   logic unused_src_h;
   assign unused_src_h = ^src_h;
`endif

   // Saturating Q.9 accumulator updates
   always_comb begin
      sx_sum = SUM_W'(sx_q) + SUM_W'(step_x_q);
      sy_sum = SUM_W'(sy_q) + SUM_W'(step_y_q);
      sx_d   = sx_sum[ACC_W] ? '1 : sx_sum[ACC_W-1:0];
      sy_d   = sy_sum[ACC_W] ? '1 : sy_sum[ACC_W-1:0];
   end

   // Split source coordinates into neighbour indices and fractions
   always_comb begin
      x0 = X_W'(sx_q[ACC_W-1:FRAC_BITS]);
      fx = sx_q[FRAC_BITS-1:0];
      y0 = X_W'(sy_q[ACC_W-1:FRAC_BITS]);
      fy = sy_q[FRAC_BITS-1:0];
`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
      if (sx_q[ACC_W-1:FRAC_BITS] >= src_w_q - DIM_W'(1)) begin
         x0 = X_W'(src_w_q - DIM_W'(1));
         fx = '0;
      end
      if (sy_q[ACC_W-1:FRAC_BITS] >= src_h_q - DIM_W'(1)) begin
         y0 = X_W'(src_h_q - DIM_W'(1));
         fy = '0;
      end
      x1 = (fx == '0 && x0 == X_W'(src_w_q - DIM_W'(1))) ? x0 : x0 + X_W'(1);
      y1 = (fy == '0 && y0 == X_W'(src_h_q - DIM_W'(1))) ? y0 : y0 + X_W'(1);
`else
      x1 = x0 + X_W'(1);
      y1 = y0 + X_W'(1);
`endif
      last_col = (col_q == dst_w_q - DIM_W'(1));
      last_row = (row_q == dst_h_q - DIM_W'(1));
   end

   // Sequencer FSM with registered strobes, addresses and payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         src_w_q  <= '0;
         dst_w_q  <= '0;
         dst_h_q  <= '0;
         step_x_q <= '0;
         step_y_q <= '0;
         sx_q     <= '0;
         sy_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         base0_q  <= '0;
         base1_q  <= '0;
         fy_q     <= '0;
         flush_q  <= '0;
         busy_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         addr0_q  <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         addr3_q  <= '0;
         pre_q    <= '0;
`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
         src_h_q  <= '0;
`endif
      end else begin
         rd_en_q    <= 1'b0;
         pre_q.en   <= 1'b0;
         pre_q.eol  <= 1'b0;
         pre_q.last <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  src_w_q  <= src_w;
                  dst_w_q  <= dst_w;
                  dst_h_q  <= dst_h;
                  step_x_q <= step_x;
                  step_y_q <= step_y;
`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
                  src_h_q  <= src_h;
`endif
                  sy_q     <= '0;
                  row_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= LINE_SETUP;
               end
            end
            LINE_SETUP: begin
               base0_q <= ADDR_W'(y0) * ADDR_W'(src_w_q);
               base1_q <= ADDR_W'(y1) * ADDR_W'(src_w_q);
               fy_q    <= fy;
               sx_q    <= '0;
               col_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               if (!hold) begin
                  rd_en_q    <= 1'b1;
                  addr0_q    <= base0_q + ADDR_W'(x0);
                  addr1_q    <= base0_q + ADDR_W'(x1);
                  addr2_q    <= base1_q + ADDR_W'(x0);
                  addr3_q    <= base1_q + ADDR_W'(x1);
                  pre_q.c1   <= COEF_ONE - COEF_W'(fx);
                  pre_q.c2   <= COEF_W'(fx);
                  pre_q.c3   <= COEF_ONE - COEF_W'(fy_q);
                  pre_q.c4   <= COEF_W'(fy_q);
                  pre_q.en   <= 1'b1;
                  pre_q.eol  <= last_col;
                  pre_q.last <= last_col && last_row;
                  if (last_col) begin
                     if (last_row) begin
                        flush_q <= '0;
                        state_q <= FLUSH;
                     end else begin
                        sy_q    <= sy_d;
                        row_q   <= row_q + DIM_W'(1);
                        state_q <= LINE_SETUP;
                     end
                  end else begin
                     sx_q  <= sx_d;
                     col_q <= col_q + DIM_W'(1);
                  end
               end
            end
            FLUSH: begin
               if (flush_q == CNT_W'(RD_LAT)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  flush_q <= flush_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   bilinear_align_dly #(
      .RD_LAT (RD_LAT)
   ) u_align_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pre_q),
      .q_o   (dly_q)
   );

   assign busy         = busy_q;
   assign rd_en        = rd_en_q;
   assign addr_bx      = addr0_q;
   assign addr_bx1     = addr1_q;
   assign addr_by      = addr2_q;
   assign addr_by1     = addr3_q;
   assign coefficient1 = dly_q.c1;
   assign coefficient2 = dly_q.c2;
   assign coefficient3 = dly_q.c3;
   assign coefficient4 = dly_q.c4;
   assign en_b         = dly_q.en;
   assign eol          = dly_q.eol;
   assign done         = dly_q.last;

endmodule

// File: tb/tb_bilinear_scale_ctrl.sv
// Self-checking bench for bilinear_scale_ctrl: two instances (read latency 1 and 3)
// share stimulus; a per-frame pixel list built from plain arithmetic is the reference.
module tb_bilinear_scale_ctrl;

   localparam int unsigned DIM_W  = 11;
   localparam int unsigned ADDR_W = 21;
   localparam int ACC_MAX  = 1048575;
   localparam int ADDR_MOD = 2097152;

   typedef struct {
      int a0, a1, a2, a3;
      int c1, c2, c3, c4;
      bit eol;
   } pix_t;

   logic clk, rst_n, start, hold;
   logic [DIM_W-1:0] src_w, src_h, dst_w, dst_h;
   logic [15:0] step_x, step_y;

   logic d_busy, d_done, d_rd_en, d_en_b, d_eol;
   logic [ADDR_W-1:0] d_a0, d_a1, d_a2, d_a3;
   logic [9:0] d_c1, d_c2, d_c3, d_c4;
   logic t_busy, t_done, t_rd_en, t_en_b, t_eol;
   logic [ADDR_W-1:0] t_a0, t_a1, t_a2, t_a3;
   logic [9:0] t_c1, t_c2, t_c3, t_c4;

   int tests = 0;
   int fails = 0;
   pix_t exp_q[$];

   bilinear_scale_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
      .step_x(step_x), .step_y(step_y), .hold(hold),
      .busy(d_busy), .done(d_done), .rd_en(d_rd_en),
      .addr_bx(d_a0), .addr_bx1(d_a1), .addr_by(d_a2), .addr_by1(d_a3),
      .coefficient1(d_c1), .coefficient2(d_c2), .coefficient3(d_c3), .coefficient4(d_c4),
      .en_b(d_en_b), .eol(d_eol)
   );

   bilinear_scale_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
      .step_x(step_x), .step_y(step_y), .hold(hold),
      .busy(t_busy), .done(t_done), .rd_en(t_rd_en),
      .addr_bx(t_a0), .addr_bx1(t_a1), .addr_by(t_a2), .addr_by1(t_a3),
      .coefficient1(t_c1), .coefficient2(t_c2), .coefficient3(t_c3), .coefficient4(t_c4),
      .en_b(t_en_b), .eol(t_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: every destination pixel of a frame in raster order
   function automatic void build_model(int sw, int sh, int dw, int dh, int stx, int sty);
      int sx, sy, x0, x1, y0, y1, fx, fy;
      int unused_h;
      pix_t p;
      unused_h = sh;
      exp_q.delete();
      for (int r = 0; r < dh; r++) begin
         sy = r * sty;
         if (sy > ACC_MAX) sy = ACC_MAX;
         y0 = sy / 512;
         fy = sy % 512;
         y1 = y0 + 1;
`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
         if (y0 >= sh - 1) begin
            y0 = sh - 1; y1 = sh - 1; fy = 0;
         end
`endif
         for (int c = 0; c < dw; c++) begin
            sx = c * stx;
            if (sx > ACC_MAX) sx = ACC_MAX;
            x0 = sx / 512;
            fx = sx % 512;
            x1 = x0 + 1;
`ifdef BILINEAR_CTRL_EDGE_CLAMP_EN
            if (x0 >= sw - 1) begin
               x0 = sw - 1; x1 = sw - 1; fx = 0;
            end
`endif
            p.a0 = (y0 * sw + x0) % ADDR_MOD;
            p.a1 = (y0 * sw + x1) % ADDR_MOD;
            p.a2 = (y1 * sw + x0) % ADDR_MOD;
            p.a3 = (y1 * sw + x1) % ADDR_MOD;
            p.c1 = 512 - fx;
            p.c2 = fx;
            p.c3 = 512 - fy;
            p.c4 = fy;
            p.eol = (c == dw - 1);
            exp_q.push_back(p);
         end
      end
   endfunction

   // One frame on both instances, checked beat by beat against the reference
   // hold_mode: 0 none, 1 random, 2 three cycles after the fifth read
   task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                            input int stx, input int sty, input int hold_mode, input bit rogue,
                            output int gaps, output int lat1, output int lat3);
      int n, rd_i, rd3_i, en_i, en3_i, cyc, first_rd, first_en, last_en, first_en3, hold_left;
      bit prev_done, prev_done3, trig, rogue_done, fin;
      pix_t e;
      n = dw * dh;
      rd_i = 0; rd3_i = 0; en_i = 0; en3_i = 0;
      first_rd = -1; first_en = -1; last_en = -1; first_en3 = -1; hold_left = 0;
      prev_done = 0; prev_done3 = 0; trig = 0; rogue_done = 0; fin = 0;
      build_model(sw, sh, dw, dh, stx, sty);
      @(negedge clk);
      src_w = DIM_W'(sw); src_h = DIM_W'(sh); dst_w = DIM_W'(dw); dst_h = DIM_W'(dh);
      step_x = 16'(stx); step_y = 16'(sty); hold = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      src_w = DIM_W'($urandom_range(1, 2047)); src_h = DIM_W'($urandom_range(1, 2047));
      dst_w = DIM_W'($urandom_range(1, 2047)); dst_h = DIM_W'($urandom_range(1, 2047));
      step_x = 16'($urandom); step_y = 16'($urandom);
      for (cyc = 0; cyc < 5000 && !fin; cyc++) begin
         if (d_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            tests++;
            if (rd_i >= n) begin
               fails++; $display("FAIL rd_extra lat1 got read %0d exp %0d reads", rd_i, n);
            end else begin
               e = exp_q[rd_i];
               if (d_a0 !== ADDR_W'(e.a0) || d_a1 !== ADDR_W'(e.a1) ||
                   d_a2 !== ADDR_W'(e.a2) || d_a3 !== ADDR_W'(e.a3)) begin
                  fails++;
                  $display("FAIL addr lat1 pix %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                           rd_i, d_a0, d_a1, d_a2, d_a3, e.a0, e.a1, e.a2, e.a3);
               end
            end
            rd_i++;
         end
         if (t_rd_en) begin
            tests++;
            if (rd3_i >= n) begin
               fails++; $display("FAIL rd_extra lat3 got read %0d exp %0d reads", rd3_i, n);
            end else begin
               e = exp_q[rd3_i];
               if (t_a0 !== ADDR_W'(e.a0) || t_a1 !== ADDR_W'(e.a1) ||
                   t_a2 !== ADDR_W'(e.a2) || t_a3 !== ADDR_W'(e.a3)) begin
                  fails++;
                  $display("FAIL addr lat3 pix %0d got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                           rd3_i, t_a0, t_a1, t_a2, t_a3, e.a0, e.a1, e.a2, e.a3);
               end
            end
            rd3_i++;
         end
         tests++;
         if (d_en_b) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (en_i >= n) begin
               fails++; $display("FAIL en_extra lat1 got beat %0d exp %0d beats", en_i, n);
            end else begin
               e = exp_q[en_i];
               if (d_c1 !== 10'(e.c1) || d_c2 !== 10'(e.c2) || d_c3 !== 10'(e.c3) ||
                   d_c4 !== 10'(e.c4) || d_eol !== e.eol || d_done !== (en_i == n - 1)) begin
                  fails++;
                  $display("FAIL coef lat1 pix %0d got %0d %0d %0d %0d eol %b done %b exp %0d %0d %0d %0d eol %b done %b",
                           en_i, d_c1, d_c2, d_c3, d_c4, d_eol, d_done,
                           e.c1, e.c2, e.c3, e.c4, e.eol, en_i == n - 1);
               end
            end
            en_i++;
         end else if (d_done !== 1'b0 || d_eol !== 1'b0) begin
            fails++; $display("FAIL stray lat1 got done %b eol %b exp 0 0", d_done, d_eol);
         end
         tests++;
         if (t_en_b) begin
            if (first_en3 < 0) first_en3 = cyc;
            if (en3_i >= n) begin
               fails++; $display("FAIL en_extra lat3 got beat %0d exp %0d beats", en3_i, n);
            end else begin
               e = exp_q[en3_i];
               if (t_c1 !== 10'(e.c1) || t_c2 !== 10'(e.c2) || t_c3 !== 10'(e.c3) ||
                   t_c4 !== 10'(e.c4) || t_eol !== e.eol || t_done !== (en3_i == n - 1)) begin
                  fails++;
                  $display("FAIL coef lat3 pix %0d got %0d %0d %0d %0d eol %b done %b exp %0d %0d %0d %0d eol %b done %b",
                           en3_i, t_c1, t_c2, t_c3, t_c4, t_eol, t_done,
                           e.c1, e.c2, e.c3, e.c4, e.eol, en3_i == n - 1);
               end
            end
            en3_i++;
         end else if (t_done !== 1'b0 || t_eol !== 1'b0) begin
            fails++; $display("FAIL stray lat3 got done %b eol %b exp 0 0", t_done, t_eol);
         end
         if (prev_done) begin
            tests++;
            if (d_busy !== 1'b0) begin
               fails++; $display("FAIL busy_drop lat1 got %b exp 0", d_busy);
            end
         end
         if (prev_done3) begin
            tests++;
            if (t_busy !== 1'b0) begin
               fails++; $display("FAIL busy_drop lat3 got %b exp 0", t_busy);
            end
         end
         prev_done  = (d_done === 1'b1);
         prev_done3 = (t_done === 1'b1);
         fin = (en_i >= n) && (en3_i >= n) && (d_busy === 1'b0) && (t_busy === 1'b0);
         case (hold_mode)
            1: hold = ($urandom_range(0, 99) < 30);
            2: begin
               if (!trig && rd_i == 5) begin
                  trig = 1; hold_left = 3;
               end
               hold = (hold_left > 0);
               if (hold_left > 0) hold_left--;
            end
            default: hold = 1'b0;
         endcase
         if (rogue && !rogue_done && rd_i >= 3) begin
            start = 1'b1; rogue_done = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      hold = 1'b0; start = 1'b0;
      tests++;
      if (!fin || rd_i != n || rd3_i != n || en_i != n || en3_i != n) begin
         fails++;
         $display("FAIL frame_count got rd %0d/%0d en %0d/%0d fin %b exp %0d each fin 1",
                  rd_i, rd3_i, en_i, en3_i, fin, n);
      end
      gaps = last_en - first_en + 1 - n;
      lat1 = first_en - first_rd;
      lat3 = first_en3 - first_rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; hold = 1'b0;
      src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; step_x = '0; step_y = '0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({d_busy, d_done, d_rd_en, d_a0, d_a1, d_a2, d_a3, d_c1, d_c2, d_c3, d_c4, d_en_b, d_eol,
           t_busy, t_done, t_rd_en, t_a0, t_a1, t_a2, t_a3, t_c1, t_c2, t_c3, t_c4, t_en_b, t_eol} !== '0) begin
         fails++; $display("FAIL reset_outputs got busy %b rd_en %b en_b %b c1 %0d exp all 0", d_busy, d_rd_en, d_en_b, d_c1);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      int gaps, lat1, lat3;
      run_frame(4, 4, 4, 4, 512, 512, 0, 1'b0, gaps, lat1, lat3);
      tests++;
      if (gaps != 3 || lat1 != 1) begin
         fails++; $display("FAIL identity_timing got gaps %0d lat %0d exp 3 1", gaps, lat1);
      end
   endtask

   task automatic test_upscale();
      int gaps, lat1, lat3;
      run_frame(2, 2, 4, 4, 256, 256, 0, 1'b0, gaps, lat1, lat3);
      tests++;
      if (gaps != 3) begin
         fails++; $display("FAIL upscale_gaps got %0d exp 3", gaps);
      end
   endtask

   task automatic test_hold();
      int gaps, lat1, lat3;
      run_frame(4, 4, 4, 4, 512, 512, 2, 1'b0, gaps, lat1, lat3);
      tests++;
      if (gaps != 6) begin
         fails++; $display("FAIL hold_gaps got %0d exp 6", gaps);
      end
   endtask

   task automatic test_rd_lat3();
      int gaps, lat1, lat3;
      run_frame(5, 3, 4, 3, 600, 300, 0, 1'b0, gaps, lat1, lat3);
      tests++;
      if (lat3 != 3 || lat1 != 1) begin
         fails++; $display("FAIL latency got lat1 %0d lat3 %0d exp 1 3", lat1, lat3);
      end
   endtask

   task automatic test_saturate();
      int gaps, lat1, lat3;
      run_frame(5, 5, 20, 18, 65535, 60000, 0, 1'b0, gaps, lat1, lat3);
      tests++;
      if (gaps != 17) begin
         fails++; $display("FAIL saturate_gaps got %0d exp 17", gaps);
      end
   endtask

   task automatic test_random();
      int gaps, lat1, lat3;
      for (int k = 0; k < 12; k++) begin
         run_frame($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
                   $urandom_range(1, 6), $urandom_range(0, 1023), $urandom_range(0, 1023),
                   1, 1'($urandom_range(0, 1)), gaps, lat1, lat3);
      end
   endtask

   task automatic test_reset_mid();
      int cnt, gaps, lat1, lat3;
      cnt = 0;
      @(negedge clk);
      src_w = 11'd4; src_h = 11'd4; dst_w = 11'd4; dst_h = 11'd4;
      step_x = 16'd512; step_y = 16'd512; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 50 && cnt < 6; i++) begin
         if (d_rd_en) cnt++;
         if (cnt < 6) @(negedge clk);
      end
      tests++;
      if (cnt != 6) begin
         fails++; $display("FAIL reset_mid_reads got %0d exp 6", cnt);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({d_busy, d_done, d_rd_en, d_a0, d_a1, d_a2, d_a3, d_c1, d_c2, d_c3, d_c4, d_en_b, d_eol,
           t_busy, t_done, t_rd_en, t_a0, t_a1, t_a2, t_a3, t_c1, t_c2, t_c3, t_c4, t_en_b, t_eol} !== '0) begin
         fails++; $display("FAIL reset_mid_outputs got busy %b rd_en %b en_b %b a0 %0d exp all 0", d_busy, d_rd_en, d_en_b, d_a0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(4, 4, 4, 4, 512, 512, 0, 1'b1, gaps, lat1, lat3);
      tests++;
      if (gaps != 3) begin
         fails++; $display("FAIL restart_gaps got %0d exp 3", gaps);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_upscale();
      test_hold();
      test_rd_lat3();
      test_saturate();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
